// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply/divide unit: one bit per cycle over WIDTH cycles,
// Start/Busy/Done handshake for pipeline stalling.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             DivByZero
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_opnd;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_result;
  logic             r_dbz;

  logic             w_last;
  logic [WIDTH:0]   w_mul_add;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH+1:0] w_diff;
  logic [WIDTH-1:0] w_hi_nxt;
  logic [WIDTH-1:0] w_lo_nxt;
  logic [WIDTH-1:0] w_result;
  logic             w_unused_diff_msb;

  assign w_last = (r_cnt == LAST_ITER);

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (Start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // One iteration of shift-add multiply or restoring divide
  always_comb begin
    w_hi_nxt  = r_hi;
    w_lo_nxt  = r_lo;
    w_mul_add = r_lo[0] ? {1'b0, r_opnd} : '0;
    w_mul_sum = {1'b0, r_hi} + w_mul_add;
    w_rem_sh  = {r_hi, r_lo[WIDTH-1]};
    w_diff    = {1'b0, w_rem_sh} - {2'b00, r_opnd};
    if (r_op[1]) begin
      if (!w_diff[WIDTH+1]) begin
        w_hi_nxt = w_diff[WIDTH-1:0];
        w_lo_nxt = {r_lo[WIDTH-2:0], 1'b1};
      end else begin
        w_hi_nxt = w_rem_sh[WIDTH-1:0];
        w_lo_nxt = {r_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      w_hi_nxt = w_mul_sum[WIDTH:1];
      w_lo_nxt = {w_mul_sum[0], r_lo[WIDTH-1:1]};
    end
    // MULHU and REMU take the upper register, MUL and DIVU the lower
    w_result = r_op[0] ? w_hi_nxt : w_lo_nxt;
  end

  // A kept subtraction always leaves a remainder below the divisor, so this bit is 0
  assign w_unused_diff_msb = w_diff[WIDTH];

  // Operand latch, iteration datapath and registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt    <= '0;
      r_op     <= '0;
      r_opnd   <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
      r_dbz    <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      r_done <= (w_state_nxt == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_op   <= Op;
            r_opnd <= Op[1] ? SrcB : SrcA;
            r_lo   <= Op[1] ? SrcA : SrcB;
            r_hi   <= '0;
            r_cnt  <= '0;
          end
        end
        S_RUN: begin
          r_hi  <= w_hi_nxt;
          r_lo  <= w_lo_nxt;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_result <= w_result;
            r_dbz    <= r_op[1] && (r_opnd == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign Busy      = r_busy;
  assign Done      = r_done;
  assign Result    = r_result;
  assign DivByZero = r_dbz;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit (WIDTH = 32): directed vectors, random
// operations against an arithmetic reference, back-to-back Start and reset abort.
module tb_mul_div_unit;

  localparam int unsigned W   = 32;
  localparam int          LAT = W + 1;

  logic         clk;
  logic         RST;
  logic         Start;
  logic [1:0]   Op;
  logic [W-1:0] SrcA;
  logic [W-1:0] SrcB;
  logic         Busy;
  logic         Done;
  logic [W-1:0] Result;
  logic         DivByZero;

  int checks   = 0;
  int failures = 0;

  mul_div_unit #(.WIDTH(W)) dut (
    .CLK       (clk),
    .RST       (RST),
    .Start     (Start),
    .Op        (Op),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .Busy      (Busy),
    .Done      (Done),
    .Result    (Result),
    .DivByZero (DivByZero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  // Reference: {DivByZero, Result} from plain unsigned arithmetic
  function automatic logic [W:0] ref_model(input logic [1:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (op)
      2'd0:    return {1'b0, p[W-1:0]};
      2'd1:    return {1'b0, p[2*W-1:W]};
      2'd2:    return (b == 0) ? {1'b1, 32'hFFFF_FFFF} : {1'b0, a / b};
      default: return (b == 0) ? {1'b1, a} : {1'b0, a % b};
    endcase
  endfunction

  // Issue one op, scramble inputs after accept, wait (bounded) for Done.
  // lat = cycles after accept edge at which Done was seen (0 on timeout).
  task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] res, output logic dbz, output int lat,
                       output int bsy);
    res = '0; dbz = 1'b0; lat = 0; bsy = 0;
    @(negedge clk);
    Start = 1'b1; Op = op; SrcA = a; SrcB = b;
    @(negedge clk);
    Start = 1'b0; Op = 2'($urandom); SrcA = $urandom; SrcB = $urandom;
    for (int c = 1; c <= 100; c++) begin
      if (c > 1) @(negedge clk);
      if (Busy) bsy++;
      if (Done) begin
        lat = c; res = Result; dbz = DivByZero;
        break;
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; Start = 1'b1; Op = 2'd0; SrcA = 32'd3; SrcB = 32'd4;
    repeat (3) @(negedge clk);
    checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", Busy); end
    checks++; if (Done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", Done); end
    checks++; if (Result !== 32'd0) begin failures++; $display("FAIL reset_result: got %h want 0", Result); end
    checks++; if (DivByZero !== 1'b0) begin failures++; $display("FAIL reset_dbz: got %b want 0", DivByZero); end
    RST = 1'b0; Start = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL reset_start_ignored: busy %b want 0", Busy); end
  endtask

  task automatic test_directed();
    logic [1:0] v_op  [9];
    logic [W-1:0] v_a [9];
    logic [W-1:0] v_b [9];
    logic [W-1:0] v_res [9];
    logic v_dbz [9];
    logic [W-1:0] res;
    logic dbz;
    int lat, bsy;
    v_op  = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd3, 2'd2, 2'd2, 2'd3, 2'd0};
    v_a   = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd100, 32'd100, 32'h8000_0000,
              32'h1234, 32'h1234, 32'd2};
    v_b   = '{32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'd7, 32'd1, 32'd0, 32'd0, 32'd3};
    v_res = '{32'h2A, 32'hFFFF_FFFE, 32'h1, 32'd14, 32'd2, 32'h8000_0000, 32'hFFFF_FFFF,
              32'h1234, 32'd6};
    v_dbz = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 9; i++) begin
      do_op(v_op[i], v_a[i], v_b[i], res, dbz, lat, bsy);
      checks++; if (res !== v_res[i]) begin failures++; $display("FAIL dir%0d_result: got %h want %h", i, res, v_res[i]); end
      checks++; if (dbz !== v_dbz[i]) begin failures++; $display("FAIL dir%0d_dbz: got %b want %b", i, dbz, v_dbz[i]); end
      checks++; if (lat !== LAT) begin failures++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, LAT); end
      checks++; if (bsy !== LAT) begin failures++; $display("FAIL dir%0d_busy_cycles: got %0d want %0d", i, bsy, LAT); end
      @(negedge clk);
      checks++;
      if (Busy !== 1'b0 || Done !== 1'b0 || Result !== v_res[i]) begin
        failures++;
        $display("FAIL dir%0d_hold: busy %b done %b result %h want 0 0 %h", i, Busy, Done, Result, v_res[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] op;
    logic [W-1:0] a, b, res;
    logic [W:0] exp;
    logic dbz;
    int lat, bsy;
    for (int i = 0; i < 24; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 255));
        default: b = $urandom;
      endcase
      exp = ref_model(op, a, b);
      do_op(op, a, b, res, dbz, lat, bsy);
      checks++; if (res !== exp[W-1:0]) begin failures++; $display("FAIL rnd%0d_result op%0d a=%h b=%h: got %h want %h", i, op, a, b, res, exp[W-1:0]); end
      checks++; if (dbz !== exp[W]) begin failures++; $display("FAIL rnd%0d_dbz: got %b want %b", i, dbz, exp[W]); end
      checks++; if (lat !== LAT) begin failures++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, lat, LAT); end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] d_op [104];
    logic [W-1:0] d_a [104];
    logic [W-1:0] d_b [104];
    int pos [3];
    logic [W-1:0] got [3];
    logic got_dbz [3];
    logic [W:0] exp;
    int n_done, bad_busy, acc, idle_at;
    n_done = 0; bad_busy = 0;
    for (int c = 0; c < 104; c++) begin
      @(negedge clk);
      if (Busy !== ((c % (W + 2)) != 0)) bad_busy++;
      if (Done === 1'b1) begin
        if (n_done < 3) begin
          pos[n_done] = c; got[n_done] = Result; got_dbz[n_done] = DivByZero;
        end
        n_done++;
      end
      d_op[c] = 2'($urandom); d_a[c] = $urandom;
      d_b[c] = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      Start = 1'b1; Op = d_op[c]; SrcA = d_a[c]; SrcB = d_b[c];
    end
    checks++; if (n_done !== 3) begin failures++; $display("FAIL b2b_done_count: got %0d want 3", n_done); end
    checks++; if (bad_busy !== 0) begin failures++; $display("FAIL b2b_busy_pattern: got %0d bad cycles want 0", bad_busy); end
    for (int k = 0; k < 3 && k < n_done; k++) begin
      checks++;
      if (pos[k] !== LAT + k * (W + 2)) begin
        failures++; $display("FAIL b2b%0d_done_pos: got %0d want %0d", k, pos[k], LAT + k * (W + 2));
      end
      acc = k * (W + 2);
      exp = ref_model(d_op[acc], d_a[acc], d_b[acc]);
      checks++; if (got[k] !== exp[W-1:0]) begin failures++; $display("FAIL b2b%0d_result: got %h want %h", k, got[k], exp[W-1:0]); end
      checks++; if (got_dbz[k] !== exp[W]) begin failures++; $display("FAIL b2b%0d_dbz: got %b want %b", k, got_dbz[k], exp[W]); end
    end
    Start = 1'b0;
    idle_at = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (Busy === 1'b0) begin idle_at = c; break; end
    end
    checks++; if (idle_at == 0) begin failures++; $display("FAIL b2b_drain: got busy after 60 cycles want idle"); end
  endtask

  task automatic test_reset_abort();
    logic [W-1:0] res;
    logic dbz;
    int lat, bsy;
    do_op(2'd0, 32'd5, 32'd9, res, dbz, lat, bsy);
    checks++; if (res !== 32'd45) begin failures++; $display("FAIL abort_pre_result: got %h want %h", res, 32'd45); end
    @(negedge clk);
    Start = 1'b1; Op = 2'd2; SrcA = 32'd1000; SrcB = 32'd3;
    @(negedge clk);
    Start = 1'b0;
    repeat (9) @(negedge clk);
    checks++; if (Busy !== 1'b1) begin failures++; $display("FAIL abort_running: busy %b want 1", Busy); end
    RST = 1'b1;
    @(negedge clk);
    RST = 1'b0;
    checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b want 0", Busy); end
    checks++; if (Done !== 1'b0) begin failures++; $display("FAIL abort_done: got %b want 0", Done); end
    checks++; if (Result !== 32'd0) begin failures++; $display("FAIL abort_result: got %h want 0", Result); end
    checks++; if (DivByZero !== 1'b0) begin failures++; $display("FAIL abort_dbz: got %b want 0", DivByZero); end
    do_op(2'd2, 32'd1000, 32'd3, res, dbz, lat, bsy);
    checks++; if (lat !== LAT) begin failures++; $display("FAIL abort_next_latency: got %0d want %0d", lat, LAT); end
    checks++; if (res !== 32'd333) begin failures++; $display("FAIL abort_next_result: got %h want %h", res, 32'd333); end
    checks++; if (dbz !== 1'b0) begin failures++; $display("FAIL abort_next_dbz: got %b want 0", dbz); end
  endtask

  initial begin
    RST = 1'b1; Start = 1'b0; Op = 2'd0; SrcA = '0; SrcB = '0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative multi-cycle multiply/divide unit that sits beside the single-cycle ALU in the RISC-V datapath. It takes the same SrcA/SrcB operands and produces 32-bit products, quotients and remainders, one bit per cycle. It uses a Start/Busy/Done handshake so the control unit can stall the pipeline until the result is ready. All arithmetic is unsigned.

## Interface
- WIDTH, 32, operand and result width in bits (must be ≥ 2)
- CLK  input  1  clock; all state changes on rising edge
- RST  input  1  synchronous, active-high reset
- Start  input  1  request; sampled only in IDLE
- Op  input  2  operation: 00 MUL (low product), 01 MULHU (high product), 10 DIVU (quotient), 11 REMU (remainder)
- SrcA  input  WIDTH  multiplicand / dividend
- SrcB  input  WIDTH  multiplier / divisor
- Busy  output  1  high while a request is in progress (RUN or DONE)
- Done  output  1  single-cycle pulse; Result valid in that cycle
- Result  output  WIDTH  selected result; holds value until next accepted Start
- DivByZero  output  1  set with Done when a DIVU/REMU had SrcB == 0; holds like Result

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: when Start = 1, latch Op, SrcA, SrcB; clear the iteration counter to 0; go to RUN. When Start = 0, stay.
- RUN: perform one iteration per cycle and increment the counter. Go to DONE after WIDTH iterations (counter reaches WIDTH-1 at the transition edge).
- DONE: Done = 1 for exactly one cycle; Result and DivByZero are updated; return to IDLE unconditionally.
- Multiply: shift-add over a 2*WIDTH product register. Each iteration: if the multiplier LSB is 1, add the multiplicand to the upper half (WIDTH+1-bit add, carry kept), then shift right 1. MUL returns bits [WIDTH-1:0]; MULHU returns [2*WIDTH-1:WIDTH].
- Divide: restoring division with a WIDTH+1-bit partial remainder. Each iteration: shift {rem, quotient} left 1, trial-subtract the divisor, keep the result if non-negative and set quotient LSB = 1, otherwise restore.
- Divide by zero needs no special datapath: the algorithm naturally yields quotient = all ones and remainder = SrcA. DivByZero = (Op[1] == 1 && latched SrcB == 0). DivByZero = 0 for MUL/MULHU.
- Latency is fixed; there is no early termination for any operand values.
- Start while Busy = 1 (including the DONE cycle) is ignored and not queued.
- Operands are latched, so SrcA/SrcB/Op may change freely after the accept edge.

## Timing
- Reset: state = IDLE; Busy = 0, Done = 0, Result = 0, DivByZero = 0; counter and internal registers cleared.
- Accept edge E0 (IDLE, Start = 1): Busy = 1 from the cycle after E0.
- Done = 1 in the cycle following edge E0 + WIDTH, i.e. WIDTH+1 cycles after the accept edge (33 for WIDTH = 32).
- Busy falls at the edge ending the DONE cycle. The earliest next accept is the cycle after DONE, giving back-to-back throughput of one op per WIDTH+2 cycles.
- Result/DivByZero are registered, change only at the edge entering DONE, and are stable through following IDLE cycles.
- RST asserted in any state (including mid-RUN or DONE): next cycle is IDLE with all outputs at reset values. No Done pulse is emitted for the aborted op.
- RST and Start high in the same cycle: reset wins and Start is not accepted.

## Test plan
- MUL 7 × 6 (WIDTH = 32) -> Done exactly 33 cycles after the accept edge, Result = 0x0000002A, DivByZero = 0, Busy high for 33 cycles.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF -> Result = 0xFFFFFFFE. The same operands with MUL -> Result = 0x00000001.
- DIVU 100 / 7 -> Result = 14. REMU 100 / 7 -> Result = 2. DIVU 0x80000000 / 1 -> 0x80000000.
- DIVU 0x1234 / 0 -> Result = 0xFFFFFFFF, DivByZero = 1. REMU 0x1234 / 0 -> Result = 0x00001234, DivByZero = 1. A following MUL 2 × 3 -> DivByZero = 0, Result = 6.
- Start held high continuously with operands changing every cycle -> first op accepted only; no re-accept until the cycle after the Done pulse; Done pulses are spaced WIDTH+2 cycles apart; each Result matches the operands latched at its accept edge.
- Assert RST 10 cycles into a DIVU -> next cycle Busy = 0, Done = 0, Result = 0. No Done pulse appears later. A new Start immediately after is accepted and completes normally.
